// File: rtl/bram_stream_fifo_pkg.sv
// Shared constants for the BRAM-backed stream FIFO and its output buffer.
package bram_stream_fifo_pkg;

  localparam int unsigned OBUF_DEPTH = 2;
  localparam int unsigned OBUF_CW    = $clog2(OBUF_DEPTH + 1);

  // Total occupancy width: RAM entries plus in-flight read plus output buffer.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/bram_stream_fifo_obuf.sv
// Two-entry register FIFO that absorbs RAM read data and presents a registered head.
module bram_stream_fifo_obuf
  import bram_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [OBUF_CW-1:0]    count
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [OBUF_CW-1:0]    count_q, count_d;
  logic [OBUF_CW-1:0]    slot;
  logic                  valid_q;

  // Pop shifts tail into head; a push lands in the first slot free after the pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    slot    = count_q - OBUF_CW'(pop);
    count_d = count_q + OBUF_CW'(push) - OBUF_CW'(pop);
    if (pop) begin
      head_d = tail_q;
    end
    if (push) begin
      if (slot == '0) begin
        head_d = push_data;
      end else begin
        tail_d = push_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign head_data  = head_q;
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/bram_stream_fifo.sv
// Valid/ready stream FIFO driving an external one-cycle registered-read RAM,
// with a two-entry output buffer hiding the read latency.
module bram_stream_fifo
  import bram_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic [DATA_WIDTH-1:0]                ENQ_DATA,
  input  logic                                 ENQ_VALID,
  output logic                                 ENQ_READY,
  output logic [DATA_WIDTH-1:0]                DEQ_DATA,
  output logic                                 DEQ_VALID,
  input  logic                                 DEQ_READY,
  output logic [count_width(ADDR_WIDTH)-1:0]   COUNT,
  output logic [DATA_WIDTH-1:0]                BRAM_DI,
  output logic [ADDR_WIDTH-1:0]                BRAM_WR_ADDR,
  output logic                                 BRAM_WE,
  output logic [ADDR_WIDTH-1:0]                BRAM_RD_ADDR,
  output logic                                 BRAM_RE,
  input  logic [DATA_WIDTH-1:0]                BRAM_DO,
  input  logic                                 BRAM_DO_VALID
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned RC_W  = ADDR_WIDTH + 1;
  localparam int unsigned CW    = count_width(ADDR_WIDTH);
  localparam int unsigned OCC_W = OBUF_CW + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [RC_W-1:0]       ram_count_q, ram_count_d;
  logic [CW-1:0]         count_q;
  logic                  inflight_q;
  logic                  enq_ready_q;
  logic                  enq_fire, deq_fire, issue;
  logic                  obuf_valid;
  logic [OBUF_CW-1:0]    obuf_count;
  logic [OCC_W-1:0]      occupancy;
  logic [1:0]            live_q;

  assign enq_fire    = ENQ_VALID & enq_ready_q;
  assign deq_fire    = obuf_valid & DEQ_READY;
  // Credit: buffered plus in-flight entries left after this cycle's dequeue.
  assign occupancy   = OCC_W'(obuf_count) + OCC_W'(inflight_q) - OCC_W'(deq_fire);
  assign issue       = (ram_count_q != '0) && (occupancy < OCC_W'(OBUF_DEPTH));
  assign ram_count_d = ram_count_q + RC_W'(enq_fire) - RC_W'(issue);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      enq_ready_q <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (issue)    rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      ram_count_q <= ram_count_d;
      count_q     <= count_q + CW'(enq_fire) - CW'(deq_fire);
      inflight_q  <= issue;
      enq_ready_q <= (ram_count_d < RC_W'(DEPTH));
    end
  end

  bram_stream_fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .push       (inflight_q),
    .push_data  (BRAM_DO),
    .pop        (deq_fire),
    .head_data  (DEQ_DATA),
    .head_valid (obuf_valid),
    .count      (obuf_count)
  );

  assign ENQ_READY    = enq_ready_q;
  assign DEQ_VALID    = obuf_valid;
  assign COUNT        = count_q;
  assign BRAM_WE      = enq_fire;
  assign BRAM_WR_ADDR = wr_ptr_q;
  assign BRAM_DI      = ENQ_DATA;
  assign BRAM_RE      = issue;
  assign BRAM_RD_ADDR = rd_ptr_q;

  // RAM's returned valid must track our in-flight flag once reset has settled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      live_q <= '0;
    end else if (live_q != 2'd2) begin
      live_q <= live_q + 2'd1;
    end
  end

  always @(posedge CLK) begin
    if (RST_N && live_q == 2'd2) begin
      assert (inflight_q == BRAM_DO_VALID);
    end
  end

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Self-checking bench for bram_stream_fifo with a behavioural registered-read RAM.
module tb_bram_stream_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = AW + 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] ENQ_DATA = '0;
  logic          ENQ_VALID = 1'b0;
  logic          ENQ_READY;
  logic [DW-1:0] DEQ_DATA;
  logic          DEQ_VALID;
  logic          DEQ_READY = 1'b0;
  logic [CW-1:0] COUNT;
  logic [DW-1:0] BRAM_DI;
  logic [AW-1:0] BRAM_WR_ADDR;
  logic          BRAM_WE;
  logic [AW-1:0] BRAM_RD_ADDR;
  logic          BRAM_RE;
  logic [DW-1:0] BRAM_DO = '0;
  logic          BRAM_DO_VALID = 1'b0;

  always #5 CLK = ~CLK;

  bram_stream_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .ENQ_DATA      (ENQ_DATA),
    .ENQ_VALID     (ENQ_VALID),
    .ENQ_READY     (ENQ_READY),
    .DEQ_DATA      (DEQ_DATA),
    .DEQ_VALID     (DEQ_VALID),
    .DEQ_READY     (DEQ_READY),
    .COUNT         (COUNT),
    .BRAM_DI       (BRAM_DI),
    .BRAM_WR_ADDR  (BRAM_WR_ADDR),
    .BRAM_WE       (BRAM_WE),
    .BRAM_RD_ADDR  (BRAM_RD_ADDR),
    .BRAM_RE       (BRAM_RE),
    .BRAM_DO       (BRAM_DO),
    .BRAM_DO_VALID (BRAM_DO_VALID)
  );

  // One-cycle registered-read RAM without reset.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (BRAM_WE) mem[BRAM_WR_ADDR] <= BRAM_DI;
    if (BRAM_RE) BRAM_DO <= mem[BRAM_RD_ADDR];
    BRAM_DO_VALID <= BRAM_RE;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Scoreboard monitor: occupancy and in-order delivery.
  bit            mon_en = 1'b0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] sb_head;
  always @(negedge CLK) begin
    if (mon_en && RST_N) begin
      chk("mon_count", 64'(COUNT), 64'(sb.size()));
      if (DEQ_VALID && DEQ_READY) begin
        if (sb.size() == 0) begin
          chk("mon_deq_nonempty", 64'd0, 64'd1);
        end else begin
          sb_head = sb.pop_front();
          chk("mon_deq_data", 64'(DEQ_DATA), 64'(sb_head));
        end
      end
      if (ENQ_VALID && ENQ_READY) sb.push_back(ENQ_DATA);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset();
    mon_en    = 1'b0;
    ENQ_VALID = 1'b0;
    DEQ_READY = 1'b0;
    RST_N     = 1'b0;
    sb.delete();
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    ENQ_VALID = 1'b0;
    DEQ_READY = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (COUNT == '0 && !DEQ_VALID) begin
        done = 1'b1;
        break;
      end
      cyc();
    end
    cyc();
    chk({name, "_drain_done"}, 64'(done), 64'd1);
    chk({name, "_drain_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  typedef struct {
    logic          ev;
    logic [DW-1:0] ed;
    logic          dr;
    logic          rdy;
    logic          we;
    logic [AW-1:0] wa;
    logic          re;
    logic [AW-1:0] ra;
    logic          dv;
    logic [DW-1:0] dd;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [13];

  int          accepts;
  int          sent;
  int          bubbles;
  int          drops;
  bit          seen_dv;
  bit          got;
  logic [DW-1:0] nxt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          ev  data    dr  rdy we wa  re ra  dv data    cnt
    tbl[0]  = '{0, 32'h0,  1,  0, 0, 0,  0, 0,  0, 32'h0,  0};
    tbl[1]  = '{1, 32'hA5, 1,  1, 1, 0,  0, 0,  0, 32'h0,  0};
    tbl[2]  = '{0, 32'h0,  1,  1, 0, 0,  1, 0,  0, 32'h0,  1};
    tbl[3]  = '{0, 32'h0,  1,  1, 0, 0,  0, 0,  0, 32'h0,  1};
    tbl[4]  = '{0, 32'h0,  1,  1, 0, 0,  0, 0,  1, 32'hA5, 1};
    tbl[5]  = '{0, 32'h0,  1,  1, 0, 0,  0, 0,  0, 32'h0,  0};
    tbl[6]  = '{1, 32'h11, 0,  1, 1, 1,  0, 0,  0, 32'h0,  0};
    tbl[7]  = '{1, 32'h22, 0,  1, 1, 2,  1, 1,  0, 32'h0,  1};
    tbl[8]  = '{0, 32'h0,  0,  1, 0, 0,  1, 2,  0, 32'h0,  2};
    tbl[9]  = '{0, 32'h0,  0,  1, 0, 0,  0, 0,  1, 32'h11, 2};
    tbl[10] = '{0, 32'h0,  1,  1, 0, 0,  0, 0,  1, 32'h11, 2};
    tbl[11] = '{0, 32'h0,  1,  1, 0, 0,  0, 0,  1, 32'h22, 1};
    tbl[12] = '{0, 32'h0,  1,  1, 0, 0,  0, 0,  0, 32'h0,  0};

    // Reset values while held in reset.
    RST_N = 1'b0;
    #3;
    chk("rst_enq_ready", 64'(ENQ_READY), 64'd0);
    chk("rst_deq_valid", 64'(DEQ_VALID), 64'd0);
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_we", 64'(BRAM_WE), 64'd0);
    chk("rst_re", 64'(BRAM_RE), 64'd0);

    // Directed single-word latency and two-word back-pressure vectors.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      ENQ_VALID = tbl[i].ev;
      ENQ_DATA  = tbl[i].ed;
      DEQ_READY = tbl[i].dr;
      @(negedge CLK);
      chk($sformatf("v%0d_enq_ready", i), 64'(ENQ_READY), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_we", i), 64'(BRAM_WE), 64'(tbl[i].we));
      if (tbl[i].we) chk($sformatf("v%0d_wr_addr", i), 64'(BRAM_WR_ADDR), 64'(tbl[i].wa));
      chk($sformatf("v%0d_re", i), 64'(BRAM_RE), 64'(tbl[i].re));
      if (tbl[i].re) chk($sformatf("v%0d_rd_addr", i), 64'(BRAM_RD_ADDR), 64'(tbl[i].ra));
      chk($sformatf("v%0d_deq_valid", i), 64'(DEQ_VALID), 64'(tbl[i].dv));
      if (tbl[i].dv) chk($sformatf("v%0d_deq_data", i), 64'(DEQ_DATA), 64'(tbl[i].dd));
      chk($sformatf("v%0d_count", i), 64'(COUNT), 64'(tbl[i].cnt));
      cyc();
    end

    // Fill with DEQ_READY low until ENQ_READY drops.
    do_reset();
    mon_en    = 1'b1;
    DEQ_READY = 1'b0;
    ENQ_VALID = 1'b1;
    nxt       = 32'h100;
    accepts   = 0;
    for (int c = 0; c < 100; c++) begin
      ENQ_DATA = nxt;
      @(negedge CLK);
      if (ENQ_READY) begin
        accepts++;
        nxt++;
      end else if (accepts > 0) begin
        break;
      end
      cyc();
    end
    chk("fill_accepts", 64'(accepts), 64'd18);
    chk("fill_count", 64'(COUNT), 64'd18);
    chk("fill_deq_valid", 64'(DEQ_VALID), 64'd1);
    chk("fill_head", 64'(DEQ_DATA), 64'h100);
    chk("fill_no_read", 64'(BRAM_RE), 64'd0);
    cyc();
    repeat (3) cyc();
    @(negedge CLK);
    chk("fill_hold_count", 64'(COUNT), 64'd18);
    chk("fill_hold_ready", 64'(ENQ_READY), 64'd0);
    cyc();

    // From full: enqueue and dequeue together across pointer wrap.
    DEQ_READY = 1'b1;
    for (int c = 0; c < 60; c++) begin
      ENQ_DATA = nxt;
      @(negedge CLK);
      chk("full_count_range", 64'(COUNT >= CW'(17) && COUNT <= CW'(18)), 64'd1);
      if (ENQ_READY) nxt++;
      cyc();
    end
    drain("full");

    // Sustained streaming: no ready drops, no output bubbles.
    do_reset();
    mon_en    = 1'b1;
    ENQ_VALID = 1'b1;
    DEQ_READY = 1'b1;
    sent = 0; bubbles = 0; drops = 0; seen_dv = 1'b0;
    for (int c = 0; c < 1100 && sent < 1000; c++) begin
      ENQ_DATA = DW'(sent);
      @(negedge CLK);
      if (c > 0 && !ENQ_READY) drops++;
      if (ENQ_READY) sent++;
      if (DEQ_VALID) seen_dv = 1'b1;
      else if (seen_dv) bubbles++;
      cyc();
    end
    chk("stream_sent", 64'(sent), 64'd1000);
    chk("stream_ready_drops", 64'(drops), 64'd0);
    chk("stream_bubbles", 64'(bubbles), 64'd0);
    drain("stream");
    chk("stream_wr_wrap", 64'(BRAM_WR_ADDR), 64'd8);
    chk("stream_rd_wrap", 64'(BRAM_RD_ADDR), 64'd8);

    // Random valid/ready traffic against the scoreboard.
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      ENQ_VALID = 1'($urandom_range(1, 0));
      DEQ_READY = 1'($urandom_range(1, 0));
      ENQ_DATA  = $urandom;
      cyc();
    end
    drain("random");

    // Asynchronous reset with entries queued and a read in flight.
    do_reset();
    mon_en    = 1'b1;
    ENQ_VALID = 1'b1;
    accepts   = 0;
    for (int c = 0; c < 20 && accepts < 5; c++) begin
      ENQ_DATA = 32'h500 + DW'(accepts);
      @(negedge CLK);
      if (ENQ_READY) accepts++;
      cyc();
    end
    ENQ_VALID = 1'b0;
    repeat (4) cyc();
    DEQ_READY = 1'b1;
    cyc();
    DEQ_READY = 1'b0;
    chk("pre_rst_count", 64'(COUNT), 64'd4);
    mon_en = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_deq_valid", 64'(DEQ_VALID), 64'd0);
    chk("async_rst_count", 64'(COUNT), 64'd0);
    chk("async_rst_enq_ready", 64'(ENQ_READY), 64'd0);
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST_N  = 1'b1;
    mon_en = 1'b1;
    ENQ_VALID = 1'b1;
    ENQ_DATA  = 32'h3C;
    DEQ_READY = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (ENQ_READY) got = 1'b1;
      cyc();
      if (got) break;
    end
    ENQ_VALID = 1'b0;
    chk("post_rst_accept", 64'(got), 64'd1);
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (DEQ_VALID) begin
        got = 1'b1;
        chk("post_rst_first", 64'(DEQ_DATA), 64'h3C);
        cyc();
        break;
      end
      cyc();
    end
    chk("post_rst_emerged", 64'(got), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("post_rst_no_stale", 64'(DEQ_VALID), 64'd0);
      cyc();
    end
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
